// File: rtl/ch_selftest_seq_if.sv
// Handshake and channel-pad bundle for the channel loopback self-test sequencer.
// master drives the requests and pad inputs; slave is the sequencer.
interface ch_selftest_seq_if;
  logic        Start;
  logic        Abort;
  logic [47:0] CH_IN;
  logic [47:0] CH_OUT;
  logic [47:0] CH_OE;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [7:0]  ErrCnt;
  logic [7:0]  FailMask;

  modport master (
    output Start, Abort, CH_IN,
    input  CH_OUT, CH_OE, Busy, Done, Pass, ErrCnt, FailMask
  );

  modport slave (
    input  Start, Abort, CH_IN,
    output CH_OUT, CH_OE, Busy, Done, Pass, ErrCnt, FailMask
  );
endinterface

// File: rtl/ch_selftest_seq.sv
// Pairwise channel loopback self-test: drives a walking-one/zero/all-ones vector set from
// each driver channel to its partner and counts receive mismatches.
module ch_selftest_seq #(
  parameter int unsigned SETTLE = 4
) (
  input logic               GLA,
  input logic               SysRst,
  ch_selftest_seq_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [2:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  mask_q, mask_d;
  logic [47:0] out_q, out_d;
  logic [47:0] oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [2:0]  rcv_ch;
  logic [2:0]  drv_ch_d;
  logic [5:0]  vec_val;
  logic [5:0]  rx_val;
  logic        active_d;

  function automatic logic [5:0] vec_lut(input logic [2:0] idx);
    logic [5:0] v;
    v = 6'h01 << idx;
    if (idx == 3'd6) v = 6'h00;
    if (idx == 3'd7) v = 6'h3F;
    return v;
  endfunction

  // Phases 0..3 drive odd channels (CH1,3,5,7) into their even partner; 4..7 reverse it.
  assign rcv_ch  = {phase_q[1:0], ~phase_q[2]};
  assign vec_val = vec_lut(vec_q);
  assign rx_val  = bus.CH_IN[6*rcv_ch +: 6];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.Start && !bus.Abort) begin
          state_d = StDrive;
          phase_d = 3'd0;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          err_d   = 8'd0;
          mask_d  = 8'd0;
        end
      end
      StDrive: begin
        cnt_d   = 8'd0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = 8'd0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCheck: begin
        if (rx_val != vec_val) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          mask_d[rcv_ch] = 1'b1;
        end
        if ({phase_q, vec_q} == 6'h3F) begin
          state_d = StDone;
        end else begin
          {phase_d, vec_d} = {phase_q, vec_q} + 6'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort discards any in-flight check result but keeps the partial tallies.
    if (busy_q && bus.Abort) begin
      state_d = StIdle;
      phase_d = 3'd0;
      vec_d   = 3'd0;
      cnt_d   = 8'd0;
      err_d   = err_q;
      mask_d  = mask_q;
    end
  end

  // Outputs are computed from next state so they are registered yet aligned with the state.
  always_comb begin
    active_d = (state_d == StDrive) || (state_d == StSettle) || (state_d == StCheck);
    drv_ch_d = {phase_d[1:0], phase_d[2]};
    out_d    = '0;
    oe_d     = '0;
    if (active_d) begin
      out_d = 48'(vec_lut(vec_d)) << (6 * drv_ch_d);
      oe_d  = 48'h3F << (6 * drv_ch_d);
    end
    busy_d = active_d;
    done_d = (state_d == StDone);
    pass_d = done_d && (err_d == 8'd0);
  end

  always_ff @(posedge GLA or negedge SysRst) begin
    if (!SysRst) begin
      state_q <= StIdle;
      phase_q <= 3'd0;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 8'd0;
      mask_q  <= 8'd0;
      out_q   <= '0;
      oe_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.CH_OUT   = out_q;
  assign bus.CH_OE    = oe_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Pass     = pass_q;
  assign bus.ErrCnt   = err_q;
  assign bus.FailMask = mask_q;

endmodule

// File: doc/ch_selftest_seq.md
CH_SELFTEST_SEQ -- requirements
Module: ch_selftest_seq

Parameters
REQ-001 SETTLE, default 4 (legal 1..255): number of settle cycles between driving a vector and sampling it.

Interface
REQ-002 GLA  input  1  system clock; all state updates on the rising edge.
REQ-003 SysRst  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  one-cycle request to begin a self-test run.
REQ-005 Abort  input  1  one-cycle request to terminate a run.
REQ-006 CH_IN  input  48  sampled channel pads; bits [6k+5:6k] belong to channel k+1.
REQ-007 CH_OUT  output  48  channel drive values; same bit layout as CH_IN.
REQ-008 CH_OE  output  48  channel output enables; same bit layout as CH_IN.
REQ-009 Busy  output  1  a run is in progress.
REQ-010 Done  output  1  the last run completed without abort.
REQ-011 Pass  output  1  Done is high and ErrCnt equals 0.
REQ-012 ErrCnt  output  8  count of mismatching checks; saturates at 255.
REQ-013 FailMask  output  8  bit k set when receiving channel k+1 mismatched at least once.

Function
REQ-014 States: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 Phase sequence has 8 phases, 0..7, as driver->receiver pairs: CH1->CH2, CH3->CH4, CH5->CH6, CH7->CH8, CH2->CH1, CH4->CH3, CH6->CH5, CH8->CH7.
REQ-016 Each phase applies 8 vectors in order: 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h3F.
REQ-017 The run is 64 vectors total, phase-major order.
REQ-018 Start sampled high in IDLE or DONE:
  - go to DRIVE on the next edge;
  - clear ErrCnt, FailMask and Done;
  - set Busy;
  - set the phase and vector indices to 0.
REQ-019 Start is ignored while Busy is high.
REQ-020 DRIVE lasts 1 cycle:
  - CH_OUT[driver] = current vector;
  - CH_OE[driver] = 6'b111111;
  - all other OE bits = 0;
  - all other OUT bits = 0.
REQ-021 SETTLE lasts exactly SETTLE cycles and holds the drive values; an internal counter counts 0..SETTLE-1.
REQ-022 CHECK lasts 1 cycle and holds the drive values.
REQ-023 In CHECK, CH_IN[receiver] is compared to the vector, non-inverted, bitwise over all 6 bits.
REQ-024 On a mismatch in CHECK:
  - ErrCnt increments by 1, saturating at 8'hFF;
  - FailMask bit of the receiver is set.
REQ-025 Leaving CHECK:
  - if vectors remain, advance to the next vector (wrapping 7->0 with phase+1) and go to DRIVE;
  - after phase 7 vector 7, go to DONE.
REQ-026 Each vector takes SETTLE+2 cycles; a full run is 64*(SETTLE+2) cycles from the first DRIVE to entry into DONE.
REQ-027 DONE:
  - Busy = 0;
  - Done = 1;
  - all CH_OE = 0 and all CH_OUT = 0;
  - Done, ErrCnt and FailMask hold until the next accepted Start.
REQ-028 Abort sampled high while Busy:
  - go to IDLE on the next edge;
  - Busy = 0 and Done = 0;
  - all OE = 0;
  - ErrCnt and FailMask retain their partial values.
REQ-029 Start and Abort high in the same cycle: Abort wins; the state stays or returns to IDLE and no run starts.
REQ-030 Abort in IDLE or DONE has no effect.
REQ-031 All outputs are registered; CH_OE and CH_OUT change only on GLA edges.
REQ-032 No two channels have OE asserted in the same cycle.

Reset
REQ-033 While SysRst is low:
  - state = IDLE;
  - CH_OUT = 0 and CH_OE = 0;
  - Busy, Done and Pass = 0;
  - ErrCnt = 0 and FailMask = 0;
  - all counters = 0.
REQ-034 Reset asserted mid-run aborts the run immediately and asynchronously, driving all OE to 0 without waiting for a clock.
REQ-035 After reset deassertion, the first run starts only on a fresh Start pulse.

Verification
REQ-036 Ideal loopback (CH_IN[receiver] = CH_OUT[driver]), SETTLE=4, Start -> Busy for 384 cycles, then Done=1, Pass=1, ErrCnt=0, FailMask=8'h00.
REQ-037 CH4 bit 2 stuck at 0, ideal elsewhere -> ErrCnt=2 (vectors 6'h04 and 6'h3F of phase 1), FailMask=8'h08, Pass=0.
REQ-038 All CH_IN tied to 0 -> 56 mismatches, ErrCnt=56, FailMask=8'hFF; with SETTLE=1, the run takes 192 cycles.
REQ-039 Abort at cycle 100 of a run -> IDLE next edge, CH_OE=0, Busy=0, Done=0, partial ErrCnt retained; a new Start restarts at phase 0 with ErrCnt cleared.
REQ-040 Start asserted again while Busy -> ignored, run length unchanged.
REQ-041 Start and Abort asserted in the same cycle -> no run.
REQ-042 SysRst pulled low mid-SETTLE -> CH_OE=0 before the next GLA edge, all outputs at reset values.
REQ-043 Every cycle of every run -> at most one channel's 6 OE bits set, and those bits belong to the current driver.
